// File: rtl/rgbled_pkg.sv
// Shared types and timing helpers for the WS281x chain controller.
package rgbled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HIGH,
        LOW,
        LATCH
    } rgbled_state_e;

    localparam longint unsigned TBitNs   = 64'd1250;
    localparam longint unsigned T0HNs    = 64'd400;
    localparam longint unsigned T1HNs    = 64'd800;
    localparam longint unsigned TLatchNs = 64'd80000;

    // Round-to-nearest clock cycles for a duration in ns, never below 1.
    function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned ns);
        longint unsigned c;
        c = (clk_hz * ns + 64'd500_000_000) / 64'd1_000_000_000;
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

endpackage

// File: rtl/rgbled_chain_ctrl_bit_tx.sv
// Single WS281x bit waveform generator: HIGH for T0H/T1H, LOW for the rest of TBit.
module rgbled_bit_tx #(
    parameter int unsigned TBit = 31,
    parameter int unsigned T0H  = 10,
    parameter int unsigned T1H  = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic bit_i,
    output logic dout_o,
    output logic high_end_o,
    output logic ready_o,
    output logic end_o
);
    localparam int unsigned CntW = $clog2(TBit + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] th;
    logic            active_q;
    logic            bit_q;
    logic            dout_q;

    always_comb begin
        th = bit_q ? CntW'(T1H) : CntW'(T0H);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            dout_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (valid_i) begin
            active_q <= 1'b1;
            bit_q    <= bit_i;
            dout_q   <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            if (cnt_q == CntW'(TBit - 1)) begin
                active_q <= 1'b0;
                dout_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                dout_q <= (cnt_q + 1'b1) < th;
            end
        end
    end

    // ready_o fires one cycle ahead of end_o so the caller can spend the last cycle fetching.
    assign dout_o     = dout_q;
    assign high_end_o = active_q && (cnt_q == th - 1'b1);
    assign ready_o    = active_q && (cnt_q == CntW'(TBit - 2));
    assign end_o      = active_q && (cnt_q == CntW'(TBit - 1));

endmodule

// File: rtl/rgbled_chain_ctrl.sv
// WS281x chain controller: colour buffer, frame sequencer and latch gap.
// Optional per-channel dimming input (dim_i) when RGBLED_DIM_EN is defined.
module rgbled_chain_ctrl
    import rgbled_pkg::*;
#(
    parameter int unsigned  NumLeds    = 2,
    parameter int unsigned  SysClkFreq = 25_000_000,
    localparam int unsigned LedAddrW   = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [LedAddrW-1:0] wr_addr_i,
    input  logic [23:0]         wr_data_i,
    input  logic                go_i,
`ifdef RGBLED_DIM_EN
    input  logic [2:0]          dim_i,
`endif
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                ws281x_dout_o
);
    localparam int unsigned TBit   = ns_to_cycles(64'(SysClkFreq), TBitNs);
    localparam int unsigned T0H    = ns_to_cycles(64'(SysClkFreq), T0HNs);
    localparam int unsigned T1H    = ns_to_cycles(64'(SysClkFreq), T1HNs);
    localparam int unsigned TLatch = ns_to_cycles(64'(SysClkFreq), TLatchNs);
    localparam int unsigned LatchW = $clog2(TLatch + 1);
    localparam logic [LedAddrW-1:0] LastLed = LedAddrW'(NumLeds - 1);

    logic [23:0]         color_q [NumLeds];
    rgbled_state_e       state_q, state_d;
    logic [LedAddrW-1:0] led_idx_q, led_idx_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [22:0]         shreg_q, shreg_d;
    logic [LatchW-1:0]   latch_cnt_q, latch_cnt_d;
    logic                pend_q, pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [23:0]         fetch_rgb;
    logic [23:0]         fetch_grb;
    logic                tx_valid, tx_bit;
    logic                tx_high_end, tx_ready, tx_end;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumLeds; i++) begin
                color_q[i] <= '0;
            end
        end else if (wr_en_i && (32'(wr_addr_i) < NumLeds)) begin
            color_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        fetch_rgb = color_q[led_idx_q];
`ifdef RGBLED_DIM_EN
        fetch_grb = {fetch_rgb[15:8] >> dim_i, fetch_rgb[23:16] >> dim_i, fetch_rgb[7:0] >> dim_i};
`else
        fetch_grb = {fetch_rgb[15:8], fetch_rgb[23:16], fetch_rgb[7:0]};
`endif
    end

    always_comb begin
        state_d     = state_q;
        led_idx_d   = led_idx_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        latch_cnt_d = latch_cnt_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tx_valid    = 1'b0;
        tx_bit      = 1'b0;

        if (go_i && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    state_d   = FETCH;
                    led_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            FETCH: begin
                tx_valid  = 1'b1;
                tx_bit    = fetch_grb[23];
                shreg_d   = fetch_grb[22:0];
                bit_cnt_d = '0;
                state_d   = HIGH;
            end
            HIGH: begin
                if (tx_high_end) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                // Last bit of an LED leaves LOW a cycle early so FETCH fills the period.
                if (bit_cnt_q == 5'd23) begin
                    if (tx_ready) begin
                        if (led_idx_q == LastLed) begin
                            state_d     = LATCH;
                            latch_cnt_d = '0;
                        end else begin
                            state_d   = FETCH;
                            led_idx_d = led_idx_q + 1'b1;
                        end
                    end
                end else if (tx_end) begin
                    tx_valid  = 1'b1;
                    tx_bit    = shreg_q[22];
                    shreg_d   = {shreg_q[21:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = HIGH;
                end
            end
            LATCH: begin
                if (latch_cnt_q == LatchW'(TLatch)) begin
                    done_d = 1'b1;
                    if (pend_q || go_i) begin
                        state_d   = FETCH;
                        led_idx_d = '0;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    latch_cnt_d = latch_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            led_idx_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            latch_cnt_q <= '0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_idx_q   <= led_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            latch_cnt_q <= latch_cnt_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    rgbled_bit_tx #(
        .TBit (TBit),
        .T0H  (T0H),
        .T1H  (T1H)
    ) u_bit_tx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (tx_valid),
        .bit_i      (tx_bit),
        .dout_o     (ws281x_dout_o),
        .high_end_o (tx_high_end),
        .ready_o    (tx_ready),
        .end_o      (tx_end)
    );

    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule
